// File: rtl/write_sequencer.sv
// write_sequencer
//   Buffers a stream of 1-bit hysteresis results in a small FIFO and issues
//   them as raster-ordered pixel writes (x, y, bit). When the last pixel of
//   the frame has been written, it raises a one-cycle dump request. The cycle
//   after that, it raises a one-cycle end-of-frame pulse.
//
//   Handshake: a pixel transfers on a rising edge where pix_valid and
//   pix_ready are both 1. pix_ready is derived only from registered state, so
//   it never depends on pix_valid or on a pop in the same cycle. Writes leave
//   on edges where the FIFO is non-empty and wr_stall is 0.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle pulse; starts a frame (honoured in IDLE only)
//   pix_valid/pix_data upstream pixel bit and its valid
//   pix_ready          pixel accepted this cycle if pix_valid is also high
//   wr_stall           write port busy; no write may issue
//   write_enable       registered write strobe
//   hysteresis_result  registered pixel bit, valid with write_enable
//   x_value/y_value    registered coordinates of the current write
//   file_dump          registered one-cycle dump request (DUMP state)
//   busy               high in every state except IDLE
//   frame_done         registered one-cycle end-of-frame pulse (DONE state)
//   dbg_state          current FSM state, for observation only
module write_sequencer #(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pix_valid,
    input  logic       pix_data,
    output logic       pix_ready,
    input  logic       wr_stall,
    output logic       write_enable,
    output logic       hysteresis_result,
    output logic [9:0] x_value,
    output logic [9:0] y_value,
    output logic       file_dump,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] dbg_state
);

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [18:0] TOTAL  = 19'(IMG_W * IMG_H);
    localparam logic [9:0]  X_LAST = 10'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

    state_t                state;
    logic [FIFO_DEPTH-1:0] mem;
    // The pointers carry one extra bit so that full and empty can be told apart.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [18:0]           acc_cnt;
    logic [18:0]           wr_cnt;
    logic [9:0]            x_cnt;
    logic [9:0]            y_cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix_ready = (state == RUN) && !full && (acc_cnt < TOTAL);
    assign push      = pix_valid && pix_ready;
    assign pop       = (state == RUN) && !empty && !wr_stall;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            mem               <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            acc_cnt           <= '0;
            wr_cnt            <= '0;
            x_cnt             <= '0;
            y_cnt             <= '0;
            write_enable      <= 1'b0;
            hysteresis_result <= 1'b0;
            x_value           <= '0;
            y_value           <= '0;
            file_dump         <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            // One-cycle strobes default low; the data outputs hold.
            write_enable <= 1'b0;
            file_dump    <= 1'b0;
            frame_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                    end
                end
                RUN: begin
                    // A push never targets the slot being popped. A push
                    // requires not full, and a pop requires not empty, so
                    // both can happen in the same cycle safely.
                    if (push) begin
                        mem[wr_ptr[AW-1:0]] <= pix_data;
                        wr_ptr              <= wr_ptr + 1'b1;
                        acc_cnt             <= acc_cnt + 19'd1;
                    end
                    if (pop) begin
                        write_enable      <= 1'b1;
                        hysteresis_result <= mem[rd_ptr[AW-1:0]];
                        x_value           <= x_cnt;
                        y_value           <= y_cnt;
                        rd_ptr            <= rd_ptr + 1'b1;
                        wr_cnt            <= wr_cnt + 19'd1;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 10'd1;
                        end else begin
                            x_cnt <= x_cnt + 10'd1;
                        end
                    end else if (wr_cnt == TOTAL) begin
                        // The last write strobe is visible this cycle, so the
                        // dump request lands in the next cycle and never
                        // overlaps it.
                        state     <= DUMP;
                        file_dump <= 1'b1;
                    end
                end
                DUMP: begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_sequencer.sv
// Directed bench for write_sequencer with a 4x2 image. Expected writes are
// queued as pixels are accepted. A negedge monitor pops and compares each
// write the DUT presents.
module tb_write_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pix_valid;
    logic       pix_data;
    logic       pix_ready;
    logic       wr_stall;
    logic       write_enable;
    logic       hysteresis_result;
    logic [9:0] x_value;
    logic [9:0] y_value;
    logic       file_dump;
    logic       busy;
    logic       frame_done;
    logic [1:0] dbg_state;

    write_sequencer #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_ready(pix_ready),
        .wr_stall(wr_stall),
        .write_enable(write_enable),
        .hysteresis_result(hysteresis_result),
        .x_value(x_value),
        .y_value(y_value),
        .file_dump(file_dump),
        .busy(busy),
        .frame_done(frame_done),
        .dbg_state(dbg_state)
    );

    // Hand-computed raster order for a 4x2 frame.
    int xt[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int yt[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    logic [20:0] exp_q[$];   // {y, x, bit}
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_writes = 0;
    int last_we_cyc = -10;
    int we_cyc[256];
    int first_acc_cyc = 0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (!rst && write_enable) begin
                we_cyc[n_writes & 255] = cyc;
                n_writes++;
                last_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_x", 32'(x_value), 32'(e[10:1]));
                    check("wr_y", 32'(y_value), 32'(e[20:11]));
                    check("wr_bit", 32'(hysteresis_result), 32'(e[0]));
                end
            end
            if (!rst && file_dump)
                check("dump_no_we_overlap", 32'(write_enable), 0);
        end
    end

    // driver tasks
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int base, input logic [7:0] data_v);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 100) begin
            pix_valid = 1'b1;
            pix_data  = data_v[base + got];
            if (pix_ready) begin
                if (base == 0 && got == 0) first_acc_cyc = cyc;
                exp_q.push_back({10'(yt[base + got]), 10'(xt[base + got]), data_v[base + got]});
                got++;
            end
            @(negedge clk);
            budget++;
        end
        pix_valid = 1'b0;
        check("feed_accepted", 32'(got), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_ready"}, 32'(pix_ready), 0);
        check({tag, "_write_enable"}, 32'(write_enable), 0);
        check({tag, "_hyst"}, 32'(hysteresis_result), 0);
        check({tag, "_x"}, 32'(x_value), 0);
        check({tag, "_y"}, 32'(y_value), 0);
        check({tag, "_file_dump"}, 32'(file_dump), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic wait_frame_end();
        int k = 0;
        while (!file_dump && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("file_dump_seen", 32'(file_dump), 1);
        if (file_dump) begin
            check("dump_after_last_we", 32'(last_we_cyc), 32'(cyc - 1));
            @(negedge clk);
            check("dump_one_cycle", 32'(file_dump), 0);
            check("frame_done_high", 32'(frame_done), 1);
            check("busy_in_done", 32'(busy), 1);
            @(negedge clk);
            check("frame_done_one_cycle", 32'(frame_done), 0);
            check("busy_low_after", 32'(busy), 0);
        end
        check("exp_q_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int w0;
        int k;
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_data = 1'b0;
        wr_stall = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // pix_valid in IDLE is ignored
        pix_valid = 1'b1;
        pix_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_pix_ready", 32'(pix_ready), 0);
            check("idle_busy", 32'(busy), 0);
        end
        pix_valid = 1'b0;
        check("idle_no_writes", 32'(n_writes), 0);

        // continuous stream, data 1,0,1,0,... plus a start pulse mid-frame
        w0 = n_writes;
        pulse_start();
        check("busy_in_run", 32'(busy), 1);
        feed(4, 0, 8'b0101_0101);
        pulse_start();
        feed(4, 4, 8'b0101_0101);
        check("ready_low_after_frame", 32'(pix_ready), 0);
        wait_frame_end();
        check("t1_write_count", 32'(n_writes - w0), 8);
        check("t1_first_latency", 32'(we_cyc[w0 & 255]), 32'(first_acc_cyc + 2));

        // stalled writer: FIFO fills, then drains back-to-back
        w0 = n_writes;
        wr_stall = 1'b1;
        pulse_start();
        feed(4, 0, 8'b0100_1011);
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stall_ready_low", 32'(pix_ready), 0);
            check("stall_no_we", 32'(write_enable), 0);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        check("stall_write_count", 32'(n_writes - w0), 0);
        wr_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_consecutive_we", 32'(write_enable), 1);
        end
        feed(4, 4, 8'b0100_1011);
        wait_frame_end();
        check("t2_write_count", 32'(n_writes - w0), 8);

        // reset mid-frame after 3 writes
        w0 = n_writes;
        pulse_start();
        feed(3, 0, 8'b0000_0101);
        k = 0;
        while (n_writes - w0 < 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_three_writes", 32'(n_writes - w0), 3);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("after_rst_quiet", 32'({file_dump, frame_done, busy, write_enable}), 0);
        end
        exp_q.delete();
        w0 = n_writes;
        pulse_start();
        feed(8, 0, 8'b1010_0110);
        wait_frame_end();
        check("t3_restart_writes", 32'(n_writes - w0), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
